// File: rtl/shift_merge_mask_24_pkg.sv
// Shared constants for the 24-bit shift-merge field-mask generator.
//   WORD_W    : mask width (only 24 supported)
//   AMT_W     : width of the lft/rht zero counts
//   MASK_ALL  : every bit selected
//   MASK_NONE : no bit selected
package shift_merge_mask_24_pkg;

  localparam int unsigned WORD_W = 24;
  localparam int unsigned AMT_W  = 5;
  // Counts are widened by one bit so sums like i + rht cannot wrap.
  localparam int unsigned EVAL_W = AMT_W + 1;

  localparam logic [0:WORD_W-1] MASK_ALL  = 24'hFFFFFF;
  localparam logic [0:WORD_W-1] MASK_NONE = 24'h000000;

endpackage

// File: rtl/shift_merge_mask_comb.sv
// Combinational field-mask decode for the shift-merge unit.
//   lft [0:4]  : zero bits at the MSB end (bit 0), 0..31
//   rht [0:4]  : zero bits at the LSB end (bit 23), 0..31
//   m   [0:23] : contiguous run of ones, m[0] = MSB
module shift_merge_mask_comb
  import shift_merge_mask_24_pkg::*;
(
  input  logic [0:AMT_W-1]  lft,
  input  logic [0:AMT_W-1]  rht,
  output logic [0:WORD_W-1] m
);

  logic [0:WORD_W-1] left_mask;
  logic [0:WORD_W-1] right_mask;
  logic [EVAL_W-1:0] lft_w;
  logic [EVAL_W-1:0] rht_w;

  assign lft_w = {1'b0, lft};
  assign rht_w = {1'b0, rht};

  // Thermometer decodes. i <= 23 - rht is evaluated as i + rht <= 23 so a
  // count of 24..31 saturates to an all-zero half-mask instead of wrapping.
  always_comb begin
    left_mask  = MASK_NONE;
    right_mask = MASK_NONE;
    for (int i = 0; i < int'(WORD_W); i++) begin
      left_mask[i]  = (EVAL_W'(i) >= lft_w);
      right_mask[i] = ((EVAL_W'(i) + rht_w) <= EVAL_W'(WORD_W - 1));
    end
  end

  // Crossed or empty fields fall out of the AND as all zeros.
  assign m = left_mask & right_mask;

endmodule

// File: rtl/shift_merge_mask_24.sv
// Registered field-mask generator for the 24-bit shift-merge unit.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   en         : capture the mask for lft/rht on this edge
//   lft [0:4]  : zero bits at the MSB end
//   rht [0:4]  : zero bits at the LSB end
//   y   [0:23] : registered mask, y[0] = MSB
//   y_vld      : high the cycle after an en cycle
module shift_merge_mask_24
  import shift_merge_mask_24_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [0:AMT_W-1]  lft,
  input  logic [0:AMT_W-1]  rht,
  output logic [0:WORD_W-1] y,
  output logic              y_vld
);

  logic [0:WORD_W-1] m;

  shift_merge_mask_comb u_comb (
    .lft (lft),
    .rht (rht),
    .m   (m)
  );

  // Output register; y holds when en is low, y_vld tracks en one cycle late.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y     <= MASK_NONE;
      y_vld <= 1'b0;
    end else begin
      y_vld <= en;
      if (en) begin
        y <= m;
      end
    end
  end

endmodule

// File: tb/tb_shift_merge_mask_24.sv
// Self-checking bench for shift_merge_mask_24: directed corner cases,
// hold/stream behaviour, an exhaustive lft/rht sweep with a mid-sweep reset,
// and a randomized en/lft/rht run against an arithmetic reference model.
module tb_shift_merge_mask_24;

  logic        clk;
  logic        rst;
  logic        en;
  logic [0:4]  lft;
  logic [0:4]  rht;
  logic [0:23] y;
  logic        y_vld;

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] exp_y;
  logic        exp_vld;

  shift_merge_mask_24 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .lft   (lft),
    .rht   (rht),
    .y     (y),
    .y_vld (y_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a run of (24 - lft - rht) ones that ends rht bits above the LSB.
  function automatic logic [23:0] ref_mask(input int l, input int r);
    longint full;
    longint low;
    if (l + r >= 24) return 24'h0;
    full = (longint'(1) << (24 - l)) - 1;
    low  = (longint'(1) << r) - 1;
    return 24'(full & ~low);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then check just after the rising edge.
  task automatic step(input int l, input int r, input bit e, input string tag);
    @(negedge clk);
    lft = 5'(l);
    rht = 5'(r);
    en  = e;
    @(posedge clk);
    #1;
    if (e) begin
      exp_y   = ref_mask(l, r);
      exp_vld = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    check($sformatf("%s y (l=%0d r=%0d en=%0d)", tag, l, r, e), 32'(y), 32'(exp_y));
    check($sformatf("%s vld (l=%0d r=%0d en=%0d)", tag, l, r, e), 32'(y_vld), 32'(exp_vld));
  endtask

  // Pulse reset between clock edges and confirm the outputs clear at once.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b0;
    en  = 1'(($urandom % 2));
    #1;
    check({tag, " y"}, 32'(y), 32'h0);
    check({tag, " vld"}, 32'(y_vld), 32'h0);
    exp_y   = 24'h0;
    exp_vld = 1'b0;
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int dir_l   [9] = '{0, 0, 0, 23, 0, 8, 12, 20, 31};
  int dir_r   [9] = '{10, 0, 0, 0, 23, 8, 12, 10, 0};
  int dir_exp [9] = '{32'hFFFC00, 32'hFFFFFF, 32'hFFFFFF, 32'h000001, 32'h800000,
                      32'h00FF00, 32'h000000, 32'h000000, 32'h000000};

  initial begin
    rst     = 1'b0;
    en      = 1'(($urandom % 2));
    lft     = 5'($urandom);
    rht     = 5'($urandom);
    exp_y   = 24'h0;
    exp_vld = 1'b0;

    // Asynchronous reset value, before any rising edge.
    #3;
    check("reset y", 32'(y), 32'h0);
    check("reset vld", 32'(y_vld), 32'h0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;

    // Directed corner cases against fixed constants.
    for (int k = 0; k < 9; k++) begin
      step(dir_l[k], dir_r[k], 1'b1, "dir");
      check($sformatf("dir const l=%0d r=%0d", dir_l[k], dir_r[k]), 32'(y), 32'(dir_exp[k]));
    end
    step(0, 24, 1'b1, "sat rht");
    check("sat rht const", 32'(y), 32'h0);

    // Hold: capture (0,10) then present new inputs with en low.
    step(0, 10, 1'b1, "hold load");
    step(5, 3, 1'b0, "hold 1");
    check("hold const", 32'(y), 32'hFFFC00);
    step(17, 1, 1'b0, "hold 2");

    // Three back-to-back captures.
    step(1, 2, 1'b1, "b2b");
    step(3, 4, 1'b1, "b2b");
    step(6, 9, 1'b1, "b2b");

    // Exhaustive sweep with a reset pulse part-way through.
    for (int l = 0; l < 32; l++) begin
      for (int r = 0; r < 32; r++) begin
        if (l == 15 && r == 16) begin
          mid_reset("sweep reset");
          step(l, r, 1'b0, "post reset idle");
          check("post reset idle y", 32'(y), 32'h0);
        end
        step(l, r, 1'b1, "sweep");
      end
    end

    // Randomized en/lft/rht stream.
    for (int k = 0; k < 200; k++) begin
      step(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           1'(($urandom % 4) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
